// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce arbiter: FSM state encoding,
// default timing constants and an index-width helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    COUNT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // 5 ms of stability at 100 MHz; 2**19 comfortably covers it
  localparam int DEFAULT_MAX   = 500_000;
  localparam int DEFAULT_CNT_W = 19;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/debounce_arbiter_sync.sv
// N-bit two-flop synchronizer for the raw button levels, synchronous reset.
module btn_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_arbiter.sv
// Round-robin debouncer sharing one stability timer among N_BTN buttons.
// Optional macro RELEASE_PULSE_EN adds btn_release, a pulse on 1->0 commits.
module debounce_arbiter
  import debounce_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter int CNT_W = DEFAULT_CNT_W,
  parameter int MAX   = DEFAULT_MAX
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_BTN-1:0]        btn_raw,
  output logic [N_BTN-1:0]        btn_db,
  output logic [N_BTN-1:0]        btn_press,
`ifdef RELEASE_PULSE_EN
  output logic [N_BTN-1:0]        btn_release,
`endif
  output logic                    busy,
  output logic [clog2(N_BTN)-1:0] grant_idx
);

  localparam int IDX_W = clog2(N_BTN);

  logic [N_BTN-1:0] sync;
  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             target, target_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_BTN-1:0] db_n;
  logic [N_BTN-1:0] press_n;
`ifdef RELEASE_PULSE_EN
  logic [N_BTN-1:0] rel_n;
`endif

  btn_sync #(.WIDTH(N_BTN)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (sync)
  );

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(N_BTN - 1)) ? '0 : v + IDX_W'(1);
  endfunction

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    idx_n    = idx;
    target_n = target;
    cnt_n    = cnt;
    db_n     = btn_db;
    press_n  = '0;
`ifdef RELEASE_PULSE_EN
    rel_n    = '0;
`endif
    case (state)
      SCAN: begin
        if (sync[ptr] != btn_db[ptr]) begin
          idx_n    = ptr;
          target_n = sync[ptr];
          cnt_n    = '0;
          state_n  = COUNT;
        end else begin
          ptr_n = wrap_inc(ptr);
        end
      end
      COUNT: begin
        // a bounce forfeits the timer; moving past idx keeps others from starving
        if (sync[idx] != target) begin
          ptr_n   = wrap_inc(idx);
          state_n = SCAN;
        end else if (cnt == CNT_W'(MAX - 1)) begin
          state_n = COMMIT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      COMMIT: begin
        // target always differs from btn_db[idx], so its value gives the edge direction
        db_n[idx]    = target;
        press_n[idx] = target;
`ifdef RELEASE_PULSE_EN
        rel_n[idx]   = ~target;
`endif
        ptr_n   = wrap_inc(idx);
        state_n = SCAN;
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      ptr         <= '0;
      idx         <= '0;
      target      <= 1'b0;
      cnt         <= '0;
      btn_db      <= '0;
      btn_press   <= '0;
`ifdef RELEASE_PULSE_EN
      btn_release <= '0;
`endif
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      idx         <= idx_n;
      target      <= target_n;
      cnt         <= cnt_n;
      btn_db      <= db_n;
      btn_press   <= press_n;
`ifdef RELEASE_PULSE_EN
      btn_release <= rel_n;
`endif
    end
  end

  assign busy      = (state == COUNT) || (state == COMMIT);
  assign grant_idx = idx;

endmodule

// File: tb/tb_debounce_arbiter.sv
// Directed bench for debounce_arbiter (N_BTN=4, MAX=8): commit events are
// scheduled into a scoreboard queue when stimulus is driven and popped by a monitor.
module tb_debounce_arbiter;

  localparam int N_BTN = 4;
  localparam int MAX   = 8;
  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] btn_db;
  logic [3:0] btn_press;
`ifdef RELEASE_PULSE_EN
  logic [3:0] btn_release;
`endif
  logic       busy;
  logic [1:0] grant_idx;

  debounce_arbiter #(.N_BTN(N_BTN), .CNT_W(CNT_W), .MAX(MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_db      (btn_db),
    .btn_press   (btn_press),
`ifdef RELEASE_PULSE_EN
    .btn_release (btn_release),
`endif
    .busy        (busy),
    .grant_idx   (grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] db;
    logic [3:0] press;
    logic [3:0] rel;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  int         now = 0;
  int         r;
  logic [3:0] prev_db = 4'b0000;
  logic [3:0] rel_obs;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      now++;
    end
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] raw);
    btn_raw = raw;
  endtask

  task automatic expect_event(input int c, input logic [3:0] db, input logic [3:0] press,
                              input logic [3:0] rel);
    exp_t e;
    e.cyc   = c;
    e.db    = db;
    e.press = press;
    e.rel   = rel;
    sb.push_back(e);
  endtask

  task automatic do_reset(input logic [3:0] raw);
    rst = 1'b1;
    applyStimulus(raw);
    tick(3);
    checkOutput("rst_db", btn_db, 4'b0000);
    checkOutput("rst_press", btn_press, 4'b0000);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_grant", grant_idx, 2'd0);
    rst = 1'b0;
  endtask

  // Every visible commit (db change or pulse) must match the head of the scoreboard
  always @(negedge clk) begin
`ifdef RELEASE_PULSE_EN
    rel_obs = btn_release;
`else
    rel_obs = 4'b0000;
`endif
    if (rst) begin
      prev_db = btn_db;
    end else if (btn_db !== prev_db || btn_press !== 4'b0000 || rel_obs !== 4'b0000) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_event", {btn_db, btn_press}, {prev_db, 4'b0000});
      end else begin
        mon_e = sb.pop_front();
        checkOutput("evt_cycle", now, mon_e.cyc);
        checkOutput("evt_db", btn_db, mon_e.db);
        checkOutput("evt_press", btn_press, mon_e.press);
`ifdef RELEASE_PULSE_EN
        checkOutput("evt_release", btn_release, mon_e.rel);
`endif
      end
      prev_db = btn_db;
    end
  end

  initial begin
    $display("[TB] start");

    // all buttons high through reset: served round-robin from where the scanner lands
    do_reset(4'b1111);
    r = now;
    expect_event(r + 12, 4'b0100, 4'b0100, 4'b0000);
    expect_event(r + 22, 4'b1100, 4'b1000, 4'b0000);
    expect_event(r + 32, 4'b1101, 4'b0001, 4'b0000);
    expect_event(r + 42, 4'b1111, 4'b0010, 4'b0000);
    tick(3);
    checkOutput("a_first_busy", busy, 1'b1);
    checkOutput("a_first_grant", grant_idx, 2'd2);
    tick(41);
    checkOutput("a_db_all", btn_db, 4'b1111);
    checkOutput("a_busy_idle", busy, 1'b0);
    checkOutput("a_drain", sb.size(), 0);

    // clean press then release of button 2
    do_reset(4'b0000);
    r = now;
    applyStimulus(4'b0100);
    expect_event(r + 12, 4'b0100, 4'b0100, 4'b0000);
    tick(13);
    checkOutput("b_busy_after_commit", busy, 1'b0);
    checkOutput("b_db_pressed", btn_db, 4'b0100);
    applyStimulus(4'b0000);
    expect_event(r + 25, 4'b0000, 4'b0000, 4'b0100);
    tick(3);
    checkOutput("b_release_busy", busy, 1'b1);
    checkOutput("b_release_grant", grant_idx, 2'd2);
    tick(10);
    checkOutput("b_db_released", btn_db, 4'b0000);
    checkOutput("b_drain", sb.size(), 0);

    // bounce on button 1 aborts; scanner resumes at 2 and finds 3 before 0
    do_reset(4'b0000);
    r = now;
    applyStimulus(4'b0010);
    tick(5);
    applyStimulus(4'b1001);
    expect_event(r + 19, 4'b1000, 4'b1000, 4'b0000);
    expect_event(r + 29, 4'b1001, 4'b0001, 4'b0000);
    tick(1);
    checkOutput("c_grant_busy", busy, 1'b1);
    checkOutput("c_grant_idx", grant_idx, 2'd1);
    tick(2);
    checkOutput("c_abort_busy", busy, 1'b0);
    checkOutput("c_abort_hold_idx", grant_idx, 2'd1);
    tick(2);
    checkOutput("c_resume_busy", busy, 1'b1);
    checkOutput("c_resume_idx", grant_idx, 2'd3);
    tick(20);
    checkOutput("c_db", btn_db, 4'b1001);
    checkOutput("c_drain", sb.size(), 0);

    // buttons 0 and 3 rise together while the scanner is about to reach 0
    do_reset(4'b0000);
    r = now;
    tick(2);
    applyStimulus(4'b1001);
    expect_event(r + 14, 4'b0001, 4'b0001, 4'b0000);
    expect_event(r + 26, 4'b1001, 4'b1000, 4'b0000);
    tick(3);
    checkOutput("d_first_grant", grant_idx, 2'd0);
    checkOutput("d_first_busy", busy, 1'b1);
    tick(12);
    checkOutput("d_second_grant", grant_idx, 2'd3);
    checkOutput("d_second_busy", busy, 1'b1);
    tick(10);
    checkOutput("d_db", btn_db, 4'b1001);
    checkOutput("d_drain", sb.size(), 0);

    // reset mid-count on button 1 discards the partial count
    do_reset(4'b0000);
    r = now;
    applyStimulus(4'b0010);
    tick(6);
    checkOutput("e_grant_idx", grant_idx, 2'd1);
    tick(5);
    do_reset(4'b0010);
    r = now;
    expect_event(r + 15, 4'b0010, 4'b0010, 4'b0000);
    tick(6);
    checkOutput("e_regrant_idx", grant_idx, 2'd1);
    checkOutput("e_regrant_busy", busy, 1'b1);
    tick(10);
    checkOutput("e_db", btn_db, 4'b0010);
    checkOutput("e_drain", sb.size(), 0);

    // button 3 glitch that is gone before the scanner arrives is never granted
    do_reset(4'b0000);
    applyStimulus(4'b1000);
    tick(1);
    applyStimulus(4'b0000);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      checkOutput("g_idle_busy", busy, 1'b0);
    end
    checkOutput("g_db", btn_db, 4'b0000);
    checkOutput("g_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
